// File: rtl/fusion_frame_scheduler.sv
// rtl/fusion_frame_scheduler.sv - three-sensor frame collector, fusion-core launcher and result tracker.
// Optional macro FUSION_SCHED_PARTIAL_TIMEOUT_EN launches a partial frame after TIMEOUT_CYCLES of collecting.
module fusion_frame_scheduler #(
   parameter int PIPE_LATENCY   = 4,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int FRAME_ID_W     = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2:0]            sens_valid,
   output logic [2:0]            sens_ready,
   output logic                  core_load,
   output logic [2:0]            lane_mask,
   input  logic [3:0]            core_error_code,
   output logic                  out_valid,
   output logic [FRAME_ID_W-1:0] out_frame_id,
   output logic [2:0]            out_lane_mask,
   output logic [3:0]            out_error,
   output logic [15:0]           err_frame_cnt,
   output logic                  busy
);
   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_LAUNCH} state_e;
   localparam int TRK_W = FRAME_ID_W + 4;

   state_e                state_q, state_d;
   logic [2:0]            arrived_q, arrived_d, accept, arrived_all;
   logic [FRAME_ID_W-1:0] frame_id_q, frame_id_d;
   logic [3:0]            err_q;
   logic [15:0]           err_cnt_q, err_cnt_d;
   logic [TRK_W-1:0]      trk_q [PIPE_LATENCY];
   logic                  trk_any;
   logic [2:0]            ready_int;
`ifdef FUSION_SCHED_PARTIAL_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0]           timer_q, timer_d;
`endif

   assign ready_int   = (state_q == S_LAUNCH) ? 3'b000 : ~arrived_q;
   assign sens_ready  = rst ? 3'b000 : ready_int;
   assign accept      = sens_valid & ready_int;
   assign arrived_all = arrived_q | accept;

   always_comb begin
      state_d    = state_q;
      arrived_d  = arrived_q;
      frame_id_d = frame_id_q;
      core_load  = 1'b0;
      lane_mask  = 3'b000;
`ifdef FUSION_SCHED_PARTIAL_TIMEOUT_EN
      timer_d    = timer_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (|accept) begin
               arrived_d = arrived_all;
               state_d   = (arrived_all == 3'b111) ? S_LAUNCH : S_COLLECT;
`ifdef FUSION_SCHED_PARTIAL_TIMEOUT_EN
               timer_d   = 16'd0;
`endif
            end
         end
         S_COLLECT: begin
            arrived_d = arrived_all;
`ifdef FUSION_SCHED_PARTIAL_TIMEOUT_EN
            timer_d   = timer_q + 16'd1;
            if (arrived_all == 3'b111 || timer_q == TMO_LAST) state_d = S_LAUNCH;
`else
            if (arrived_all == 3'b111) state_d = S_LAUNCH;
`endif
         end
         S_LAUNCH: begin
            core_load  = 1'b1;
`ifdef FUSION_SCHED_PARTIAL_TIMEOUT_EN
            lane_mask  = arrived_q;
`else
            lane_mask  = 3'b111;
`endif
            arrived_d  = 3'b000;
            frame_id_d = frame_id_q + 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         arrived_q  <= 3'b000;
         frame_id_q <= '0;
         err_q      <= 4'h0;
         err_cnt_q  <= 16'h0000;
`ifdef FUSION_SCHED_PARTIAL_TIMEOUT_EN
         timer_q    <= 16'd0;
`endif
      end else begin
         state_q    <= state_d;
         arrived_q  <= arrived_d;
         frame_id_q <= frame_id_d;
         err_q      <= core_error_code;
         err_cnt_q  <= err_cnt_d;
`ifdef FUSION_SCHED_PARTIAL_TIMEOUT_EN
         timer_q    <= timer_d;
`endif
      end
   end

   // Tracker entries are zero when empty, so the tail also supplies the zeroed idle outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PIPE_LATENCY; i++) trk_q[i] <= '0;
      end else begin
         trk_q[0] <= core_load ? {1'b1, frame_id_q, lane_mask} : '0;
         for (int i = 1; i < PIPE_LATENCY; i++) trk_q[i] <= trk_q[i-1];
      end
   end

   always_comb begin
      trk_any = 1'b0;
      for (int i = 0; i < PIPE_LATENCY; i++) trk_any = trk_any | trk_q[i][TRK_W-1];
   end

   assign out_valid     = trk_q[PIPE_LATENCY-1][TRK_W-1];
   assign out_frame_id  = out_valid ? trk_q[PIPE_LATENCY-1][FRAME_ID_W+2:3] : '0;
   assign out_lane_mask = out_valid ? trk_q[PIPE_LATENCY-1][2:0] : 3'b000;
   assign out_error     = out_valid ? err_q : 4'h0;
   assign err_frame_cnt = err_cnt_q;
   assign busy          = (state_q != S_IDLE) || trk_any;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (out_valid && (out_error != 4'h0 || out_lane_mask != 3'b111) && err_cnt_q != 16'hFFFF)
         err_cnt_d = err_cnt_q + 16'd1;
   end
endmodule

// File: tb/tb_fusion_frame_scheduler.sv
// tb/tb_fusion_frame_scheduler.sv - scoreboard bench for fusion_frame_scheduler.
module tb_fusion_frame_scheduler;
   localparam int LAT = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] sens_valid = 3'b000;
   logic [2:0] sens_ready;
   logic       core_load;
   logic [2:0] lane_mask;
   logic [3:0] core_error_code = 4'h0;
   logic       out_valid;
   logic [7:0] out_frame_id;
   logic [2:0] out_lane_mask;
   logic [3:0] out_error;
   logic [15:0] err_frame_cnt;
   logic       busy;

   fusion_frame_scheduler #(.PIPE_LATENCY(LAT), .TIMEOUT_CYCLES(64), .FRAME_ID_W(8)) dut (
      .clk(clk), .rst(rst), .sens_valid(sens_valid), .sens_ready(sens_ready),
      .core_load(core_load), .lane_mask(lane_mask), .core_error_code(core_error_code),
      .out_valid(out_valid), .out_frame_id(out_frame_id), .out_lane_mask(out_lane_mask),
      .out_error(out_error), .err_frame_cnt(err_frame_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] id;
      logic [2:0] mask;
      logic [3:0] err;
      int         due;
   } exp_t;

   exp_t       sb_q[$];
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         load_cnt = 0;
   int         last_load_cyc = 0;
   logic [7:0] exp_id = 8'd0;
   logic [2:0] exp_mask = 3'b111;
   logic [3:0] exp_err = 4'h0;
   logic [15:0] exp_cnt = 16'h0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: loads push expectations, results pop and compare.
   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
         exp_id  = 8'd0;
         exp_cnt = 16'h0;
      end else begin
         if (core_load) begin
            check_val("load_mask", 32'(lane_mask), 32'(exp_mask));
            sb_q.push_back('{id: exp_id, mask: exp_mask, err: exp_err, due: cyc + LAT});
            exp_id = exp_id + 8'd1;
            load_cnt++;
            last_load_cyc = cyc;
         end
         if (out_valid) begin
            if (sb_q.size() == 0) begin
               check_val("spurious_out", 32'(out_valid), 32'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check_val("out_id", 32'(out_frame_id), 32'(e.id));
               check_val("out_mask", 32'(out_lane_mask), 32'(e.mask));
               check_val("out_err", 32'(out_error), 32'(e.err));
               check_val("out_cycle", cyc, e.due);
               if ((e.err != 4'h0 || e.mask != 3'b111) && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int i = 0; i < 400 && !done; i++) begin
         step();
         if (!busy) done = 1;
      end
      check_val("idle_timeout", 32'(done), 32'd1);
   endtask

   task automatic wait_load(input int base, input int limit);
      for (int i = 0; i < limit && load_cnt == base; i++) step();
      check_val("load_timeout", load_cnt, base + 1);
   endtask

   task automatic check_all_zero(input string tag);
      check_val(tag, {sens_ready, core_load, lane_mask, out_valid, out_frame_id, out_lane_mask, out_error, busy},
                32'd0);
      check_val({tag, "_cnt"}, 32'(err_frame_cnt), 32'd0);
   endtask

   task automatic full_frame();
      sens_valid = 3'b111;
      step();
      sens_valid = 3'b000;
      wait_idle();
   endtask

   initial begin
      int t;
      int base;
      int prev;
      int n;

      // Reset state and first cycle after release
      repeat (3) step();
      @(negedge clk);
      check_all_zero("reset_outputs");
      step();
      rst = 1'b0;
      @(negedge clk);
      check_val("ready_after_rst", 32'(sens_ready), 32'd7);

      // All lanes at once: launch next cycle, result LAT later
      step();
      sens_valid = 3'b111;
      t = cyc;
      step();
      sens_valid = 3'b000;
      @(negedge clk);
      check_val("t35_load", 32'(core_load), 32'd1);
      check_val("t35_cycle", cyc, t + 1);
      wait_idle();
      check_val("t35_cnt", 32'(err_frame_cnt), 32'd0);

      // Lanes 0,2 first, lane 1 five cycles later
      sens_valid = 3'b101;
      base = load_cnt;
      for (int k = 1; k <= 5; k++) begin
         step();
         sens_valid = (k == 5) ? 3'b010 : 3'b000;
         @(negedge clk);
         check_val("t36_ready", 32'(sens_ready), 32'd2);
         check_val("t36_noload", 32'(core_load), 32'd0);
      end
      step();
      sens_valid = 3'b000;
      @(negedge clk);
      check_val("t36_load", 32'(core_load), 32'd1);
      wait_idle();
      check_val("t36_single", load_cnt, base + 1);

      // Single lane: timeout launch or indefinite wait
      base = load_cnt;
`ifdef FUSION_SCHED_PARTIAL_TIMEOUT_EN
      exp_mask = 3'b010;
      sens_valid = 3'b010;
      t = cyc;
      step();
      sens_valid = 3'b000;
      wait_load(base, 200);
      check_val("t37_load_cycle", last_load_cyc, t + 65);
      wait_idle();
      check_val("t37_cnt", 32'(err_frame_cnt), 32'(exp_cnt));
      check_val("t37_cnt_one", 32'(err_frame_cnt), 32'd1);
      exp_mask = 3'b111;
`else
      sens_valid = 3'b010;
      step();
      sens_valid = 3'b000;
      repeat (1000) step();
      check_val("t37_noload", load_cnt, base);
      check_val("t37_busy", 32'(busy), 32'd1);
      sens_valid = 3'b101;
      step();
      sens_valid = 3'b000;
      wait_load(base, 20);
      wait_idle();
      check_val("t37_cnt", 32'(err_frame_cnt), 32'd0);
`endif

      // 257 back-to-back frames from a fresh reset
      rst = 1'b1;
      step();
      rst = 1'b0;
      sens_valid = 3'b111;
      n = 0;
      prev = 0;
      for (int i = 0; i < 700 && n < 257; i++) begin
         @(negedge clk);
         if (core_load) begin
            if (n > 0) check_val("t38_interval", cyc - prev, 2);
            prev = cyc;
            n++;
            if (n == 257) sens_valid = 3'b000;
         end
      end
      check_val("t38_count", n, 257);
      wait_idle();
      check_val("t38_next_id", 32'(exp_id), 32'd1);

      // Fault code on a completing frame, then saturation
      core_error_code = 4'h3;
      exp_err = 4'h3;
      full_frame();
      check_val("t39_cnt", 32'(err_frame_cnt), 32'(exp_cnt));
      check_val("t39_cnt_one", 32'(err_frame_cnt), 32'd1);
      force dut.err_cnt_q = 16'hFFFE;
      step();
      release dut.err_cnt_q;
      exp_cnt = 16'hFFFE;
      step();
      check_val("t39_preload", 32'(err_frame_cnt), 32'hFFFE);
      full_frame();
      full_frame();
      check_val("t39_sat", 32'(err_frame_cnt), 32'hFFFF);
      check_val("t39_sat_model", 32'(err_frame_cnt), 32'(exp_cnt));
      core_error_code = 4'h0;
      exp_err = 4'h0;

      // Reset with two frames in flight
      sens_valid = 3'b111;
      n = 0;
      for (int i = 0; i < 20 && n < 2; i++) begin
         @(negedge clk);
         if (core_load) begin
            n++;
            if (n == 2) sens_valid = 3'b000;
         end
      end
      step();
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("t40_in_rst");
      step();
      rst = 1'b0;
      @(negedge clk);
      check_val("t40_ready", 32'(sens_ready), 32'd7);
      repeat (20) step();
      check_val("t40_quiet", 32'(busy), 32'd0);
      check_val("t40_pending", sb_q.size(), 0);
      full_frame();
      check_val("t40_id_next", 32'(exp_id), 32'd1);

      check_val("sb_empty", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
